// File: rtl/vec_dotprod_pkg.sv
// Shared types and constants for the vec_dotprod block: FSM encoding and
// the number of register stages between a beat issue and its accumulate.
package vec_dotprod_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PIPE_DEPTH = 3;

endpackage

// File: rtl/dotprod_adder_tree.sv
// Combinational balanced adder tree: LANES signed 2*DW products, each
// sign-extended to AW bits, reduced pairwise over log2(LANES) levels.
module dotprod_adder_tree #(
  parameter int DW    = 32,
  parameter int AW    = 64,
  parameter int LANES = 4
) (
  input  logic [LANES*2*DW-1:0] prods,
  output logic [AW-1:0]         sum
);

  localparam int LG = $clog2(LANES);

  logic [AW-1:0] lvl [0:LG][0:LANES-1];

  genvar gi, gj;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_leaf
      assign lvl[0][gi] = AW'($signed(prods[gi*2*DW +: 2*DW]));
    end
    for (gi = 0; gi < LG; gi++) begin : g_level
      for (gj = 0; gj < LANES; gj++) begin : g_node
        if (gj < (LANES >> (gi + 1))) begin : g_add
          assign lvl[gi+1][gj] = lvl[gi][2*gj] + lvl[gi][2*gj+1];
        end else begin : g_unused
          assign lvl[gi+1][gj] = '0;
        end
      end
    end
  endgenerate

  assign sum = lvl[LG][0];

endmodule

// File: rtl/vec_dotprod.sv
// Streaming signed dot product over two LANES-wide memories.
// Define VEC_DOTPROD_SAT_EN for a clamping accumulator and a sticky sat output.
module vec_dotprod
  import vec_dotprod_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 64,
  parameter int LANES = 4,
  parameter int NW    = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                start,
  input  logic [NW-1:0]       n,
  input  logic [NW-1:0]       a_base,
  input  logic [NW-1:0]       b_base,
  output logic                a_en,
  output logic                b_en,
  output logic [NW-1:0]       a_addr,
  output logic [NW-1:0]       b_addr,
  input  logic [LANES*DW-1:0] a_rdata,
  input  logic [LANES*DW-1:0] b_rdata,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       result
`ifdef VEC_DOTPROD_SAT_EN
  ,
  output logic                sat
`endif
);

  localparam int LG = $clog2(LANES);
  localparam int LW = LANES * DW;
  localparam int PW = LANES * 2 * DW;

  state_t            state_q, state_d;
  logic [NW-1:0]     n_q, n_d, a_base_q, a_base_d, b_base_q, b_base_d;
  logic [NW-1:0]     beats_q, beats_d, beat_q, beat_d, tail;
  logic [1:0]        drain_q, drain_d;
  logic              last_beat;
  logic              iss_v_q, iss_v_d, cap_v_q, prod_v_q;
  logic [LANES-1:0]  iss_mask_q, iss_mask_d;
  logic [LW-1:0]     cap_a_q, cap_a_d, cap_b_q, cap_b_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [AW-1:0]     lane_sum, acc_sum, acc_q, acc_d, result_q, result_d;
`ifdef VEC_DOTPROD_SAT_EN
  logic              sat_q, sat_d, acc_ovf;
  logic [AW:0]       acc_wide;
`endif

  // Lanes past n on the final beat are zeroed at capture, whatever the memory returns.
  assign last_beat = (beat_q == beats_q - NW'(1));
  assign tail      = n_q - ((beats_q - NW'(1)) << LG);
  assign iss_v_d   = (state_q == FETCH);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign iss_mask_d[gi]           = !last_beat || (NW'(gi) < tail);
      assign cap_a_d[gi*DW +: DW]     = iss_mask_q[gi] ? a_rdata[gi*DW +: DW] : '0;
      assign cap_b_d[gi*DW +: DW]     = iss_mask_q[gi] ? b_rdata[gi*DW +: DW] : '0;
      assign prod_d[gi*2*DW +: 2*DW]  = (2*DW)'($signed(cap_a_q[gi*DW +: DW]))
                                      * (2*DW)'($signed(cap_b_q[gi*DW +: DW]));
    end
  endgenerate

  dotprod_adder_tree #(.DW(DW), .AW(AW), .LANES(LANES)) u_tree (
    .prods (prod_q),
    .sum   (lane_sum)
  );

  always_comb begin
`ifdef VEC_DOTPROD_SAT_EN
    acc_wide = {acc_q[AW-1], acc_q} + {lane_sum[AW-1], lane_sum};
    acc_ovf  = acc_wide[AW] ^ acc_wide[AW-1];
    if (!acc_ovf)         acc_sum = acc_wide[AW-1:0];
    else if (acc_wide[AW]) acc_sum = {1'b1, {(AW-1){1'b0}}};
    else                   acc_sum = {1'b0, {(AW-1){1'b1}}};
`else
    acc_sum = acc_q + lane_sum;
`endif
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    beats_d  = beats_q;
    beat_d   = beat_q;
    drain_d  = drain_q;
    result_d = result_q;
    acc_d    = prod_v_q ? acc_sum : acc_q;
`ifdef VEC_DOTPROD_SAT_EN
    sat_d    = sat_q | (prod_v_q & acc_ovf);
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d      = n;
          a_base_d = a_base;
          b_base_d = b_base;
          beats_d  = NW'(({1'b0, n} + (NW+1)'(LANES - 1)) >> LG);
          beat_d   = '0;
          drain_d  = '0;
          acc_d    = '0;
`ifdef VEC_DOTPROD_SAT_EN
          sat_d    = 1'b0;
`endif
          if (n == '0) begin
            state_d  = DONE;
            result_d = '0;
          end else begin
            state_d  = FETCH;
          end
        end
      end
      FETCH: begin
        if (last_beat) state_d = DRAIN;
        else           beat_d  = beat_q + NW'(1);
      end
      DRAIN: begin
        // The final product is added on the same edge that enters DONE.
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'(PIPE_DEPTH - 1)) begin
          state_d  = DONE;
          result_d = acc_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      beats_q    <= '0;
      beat_q     <= '0;
      drain_q    <= '0;
      iss_v_q    <= 1'b0;
      iss_mask_q <= '0;
      cap_v_q    <= 1'b0;
      cap_a_q    <= '0;
      cap_b_q    <= '0;
      prod_v_q   <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      result_q   <= '0;
`ifdef VEC_DOTPROD_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      a_base_q   <= a_base_d;
      b_base_q   <= b_base_d;
      beats_q    <= beats_d;
      beat_q     <= beat_d;
      drain_q    <= drain_d;
      iss_v_q    <= iss_v_d;
      iss_mask_q <= iss_mask_d;
      cap_v_q    <= iss_v_q;
      cap_a_q    <= cap_a_d;
      cap_b_q    <= cap_b_d;
      prod_v_q   <= cap_v_q;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
`ifdef VEC_DOTPROD_SAT_EN
      sat_q      <= sat_d;
`endif
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign a_en   = (state_q == FETCH);
  assign b_en   = (state_q == FETCH);
  assign a_addr = a_base_q + beat_q;
  assign b_addr = b_base_q + beat_q;
  assign result = result_q;
`ifdef VEC_DOTPROD_SAT_EN
  assign sat    = sat_q;
`endif

endmodule

// File: tb/tb_vec_dotprod.sv
// Scoreboard bench for vec_dotprod: a LANES=1 and a LANES=4 instance,
// directed vectors, expected results queued at issue and checked on done.
module tb_vec_dotprod;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int NW = 16;

  typedef struct {
    logic [AW-1:0] res;
    int            cyc;
    logic          sat;
    string         name;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start [2];
  logic [NW-1:0] n_in [2];
  logic [NW-1:0] a_base [2];
  logic [NW-1:0] b_base [2];
  logic          a_en [2];
  logic          b_en [2];
  logic [NW-1:0] a_addr [2];
  logic [NW-1:0] b_addr [2];
  logic [63:0]   a_rd [2];
  logic [63:0]   b_rd [2];
  logic          busy [2];
  logic          done [2];
  logic [AW-1:0] result [2];
`ifdef VEC_DOTPROD_SAT_EN
  logic          sat [2];
`endif

  logic [63:0] mem_a [2][0:63];
  logic [63:0] mem_b [2][0:63];
  exp_t        exp_q [2][$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          en_seen [2];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LN = (gi == 0) ? 1 : 4;
      vec_dotprod #(.DW(DW), .AW(AW), .LANES(LN), .NW(NW)) u_dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .start     (start[gi]),
        .n         (n_in[gi]),
        .a_base    (a_base[gi]),
        .b_base    (b_base[gi]),
        .a_en      (a_en[gi]),
        .b_en      (b_en[gi]),
        .a_addr    (a_addr[gi]),
        .b_addr    (b_addr[gi]),
        .a_rdata   (a_rd[gi][LN*DW-1:0]),
        .b_rdata   (b_rd[gi][LN*DW-1:0]),
        .busy      (busy[gi]),
        .done      (done[gi]),
        .result    (result[gi])
`ifdef VEC_DOTPROD_SAT_EN
        ,
        .sat       (sat[gi])
`endif
      );
    end
  endgenerate

  // Memory model: one-cycle read latency, 64-word depth (addresses wrap on the low 6 bits).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (a_en[k]) a_rd[k] <= mem_a[k][a_addr[k][5:0]];
      if (b_en[k]) b_rd[k] <= mem_b[k][b_addr[k][5:0]];
    end
  end

  // Monitor: pops one expectation per done pulse; done with nothing queued is an error.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (a_en[k] || b_en[k]) en_seen[k]++;
      if (done[k]) begin
        checks++;
        if (exp_q[k].size() == 0) begin
          errors++;
          $display("FAIL unexpected_done inst%0d: done=1 result=%0d at cycle %0d, required no done",
                   k, $signed(result[k]), cyc);
        end else begin
          e = exp_q[k].pop_front();
          if (result[k] !== e.res) begin
            errors++;
            $display("FAIL %s_result inst%0d: got %0d, required %0d", e.name, k,
                     $signed(result[k]), $signed(e.res));
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL %s_latency inst%0d: done at cycle %0d, required %0d", e.name, k, cyc, e.cyc);
          end
`ifdef VEC_DOTPROD_SAT_EN
          checks++;
          if (sat[k] !== e.sat) begin
            errors++;
            $display("FAIL %s_sat inst%0d: got %0b, required %0b", e.name, k, sat[k], e.sat);
          end
`endif
          $display("inst%0d %-10s result=%0d done_cycle=%0d", k, e.name, $signed(result[k]), cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, expv);
    end
  endtask

  task automatic wait_idle(input int k, input string name);
    int i;
    for (i = 0; i < 200 && busy[k]; i++) @(negedge clk);
    checks++;
    if (busy[k]) begin
      errors++;
      $display("FAIL %s_timeout inst%0d: busy=1 after 200 cycles, required 0", name, k);
    end
    @(negedge clk);
  endtask

  // Done is expected as the value sampled by the lat-th edge after the accepting edge,
  // i.e. visible at the negedge whose cycle count is accept + lat - 1.
  task automatic run(input int k, input int nn, input int ab, input int bb,
                     input logic [AW-1:0] res, input logic s, input string name,
                     input bit poke);
    int ln  = (k == 0) ? 1 : 4;
    int nb  = (nn + ln - 1) / ln;
    int lat = (nn == 0) ? 1 : nb + 4;
    @(negedge clk);
    start[k]  = 1'b1;
    n_in[k]   = NW'(nn);
    a_base[k] = NW'(ab);
    b_base[k] = NW'(bb);
    exp_q[k].push_back('{res, cyc + lat, s, name});
    @(negedge clk);
    if (poke) begin
      n_in[k]   = NW'(3);
      a_base[k] = NW'(0);
      @(negedge clk);
    end
    start[k] = 1'b0;
    wait_idle(k, name);
  endtask

  task automatic chk_reset(input int k, input string tag);
    chk({tag, "_busy"},   64'(busy[k]),   64'd0);
    chk({tag, "_done"},   64'(done[k]),   64'd0);
    chk({tag, "_a_en"},   64'(a_en[k]),   64'd0);
    chk({tag, "_b_en"},   64'(b_en[k]),   64'd0);
    chk({tag, "_a_addr"}, 64'(a_addr[k]), 64'd0);
    chk({tag, "_b_addr"}, 64'(b_addr[k]), 64'd0);
    chk({tag, "_result"}, 64'(result[k]), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] sat_res;
    logic          sat_flag;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; n_in[k] = '0; a_base[k] = '0; b_base[k] = '0; en_seen[k] = 0;
      for (int w = 0; w < 64; w++) begin
        mem_a[k][w] = 64'h0;
        mem_b[k][w] = 64'h0;
      end
    end
    // LANES=1 data
    for (int j = 0; j < 4; j++) begin
      mem_a[0][10+j] = 64'(j + 1);
      mem_b[0][20+j] = 64'(j + 5);
      mem_a[0][40+j] = 64'h8000;
      mem_b[0][40+j] = 64'h8000;
    end
    mem_a[0][63] = 64'd3;  mem_a[0][0] = 64'd5;
    mem_b[0][30] = 64'd2;  mem_b[0][31] = 64'd4;
    // LANES=4 data, lane 0 in the low 16 bits
    mem_a[1][5]  = {16'd4, 16'd3, 16'd2, 16'd1};
    mem_b[1][7]  = {16'd8, 16'd7, 16'd6, 16'd5};
    mem_a[1][8]  = {4{16'd2}};  mem_a[1][9] = {4{16'd2}};
    mem_b[1][8]  = {4{16'd2}};  mem_b[1][9] = {4{16'd2}};
    mem_a[1][12] = {16'h1234, 16'h1234, 16'd7, 16'hFFFD};
    mem_b[1][12] = {16'h5555, 16'h5555, 16'hFFFE, 16'd4};
    mem_a[1][14] = {16'd4, 16'd3, 16'd2, 16'd1};
    mem_a[1][15] = {16'd8, 16'd7, 16'd6, 16'd5};
    mem_b[1][16] = {4{16'd1}};  mem_b[1][17] = {4{16'd1}};
`ifdef VEC_DOTPROD_SAT_EN
    sat_res = 32'h7FFF_FFFF; sat_flag = 1'b1;
`else
    sat_res = 32'h0;         sat_flag = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk_reset(0, "por_inst0");
    chk_reset(1, "por_inst1");
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 4, 10, 20, 32'd70, 1'b0, "dot70", 1'b0);
    en_seen[0] = 0;
    run(0, 0, 10, 20, 32'd0, 1'b0, "n0_hold", 1'b1);
    chk("n0_a_en_never_high", 64'(en_seen[0]), 64'd0);
    run(0, 2, 16'hFFFF, 30, 32'd26, 1'b0, "addr_wrap", 1'b0);
    run(0, 4, 40, 40, sat_res, sat_flag, "sat_wrap", 1'b0);

    // Abort mid-FETCH: no expectation queued, so any done would be flagged.
    @(negedge clk);
    start[0] = 1'b1; n_in[0] = NW'(4); a_base[0] = NW'(10); b_base[0] = NW'(20);
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    chk("abort_in_fetch", 64'(a_en[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset(0, "abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run(0, 4, 10, 20, 32'd70, 1'b0, "dot70_rst", 1'b0);

    run(1, 4, 5, 7, 32'd70, 1'b0, "dot70_l4", 1'b0);
    run(1, 5, 8, 8, 32'd20, 1'b0, "tail_mask", 1'b0);
    run(1, 2, 12, 12, 32'hFFFF_FFE6, 1'b0, "signed", 1'b1);
    run(1, 8, 14, 16, 32'd36, 1'b0, "two_beats", 1'b0);
    en_seen[1] = 0;
    run(1, 0, 14, 16, 32'd0, 1'b0, "n0_l4", 1'b0);
    chk("n0_l4_a_en_never_high", 64'(en_seen[1]), 64'd0);

    repeat (10) @(negedge clk);
    chk("queue_empty_inst0", 64'(exp_q[0].size()), 64'd0);
    chk("queue_empty_inst1", 64'(exp_q[1].size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vec_dotprod.md
VEC_DOTPROD -- requirements
Module: vec_dotprod

Interface
REQ-001 Parameter DW, default 32: element width in bits, signed two's complement.
REQ-002 Parameter AW, default 64: accumulator and result width in bits; AW >= 2*DW.
REQ-003 Parameter LANES, default 4: elements consumed per beat, power of two, 1..16.
REQ-004 Parameter NW, default 16: element-count width; also the address width.
REQ-005 Port sys_clk, input, 1: clock, rising edge.
REQ-006 Port sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port start, input, 1: request; accepted only in IDLE.
REQ-008 Port n, input, NW: element count; latched on accept.
REQ-009 Port a_base / b_base, input, NW each: beat-word base addresses; latched on accept.
REQ-010 Port a_en / b_en, output, 1 each: memory read enables.
REQ-011 Port a_addr / b_addr, output, NW each: beat-word addresses.
REQ-012 Port a_rdata / b_rdata, input, LANES*DW each: read data, valid exactly one cycle after the enable; lane i occupies bits [i*DW +: DW].
REQ-013 Port busy, output, 1: high from the accepting edge through the done cycle.
REQ-014 Port done, output, 1: single-cycle completion pulse.
REQ-015 Port result, output, AW: dot product; held stable until the next accept.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, DRAIN and DONE.
- IDLE -> FETCH on start with n>0.
- IDLE -> DONE on start with n==0; result becomes 0.
- FETCH -> DRAIN after the last beat issue.
- DRAIN -> DONE after the last accumulate.
- DONE -> IDLE after one cycle.
REQ-017 Beat count B SHALL be ceil(n/LANES); beat k SHALL drive a_addr=a_base+k and b_addr=b_base+k with a_en=b_en=1, one beat per cycle, with no stalls.
REQ-018 On the final beat, lanes with index >= n-(B-1)*LANES SHALL contribute zero regardless of rdata.
REQ-019 The pipeline SHALL be: issue, then data capture, then per-lane 2*DW signed product register, then lane sum sign-extended to AW and added to the accumulator.
REQ-020 The accumulator SHALL clear on accept; result SHALL update when entering DONE.
REQ-021 For n>0, done SHALL assert on the (B+4)th rising edge after the accepting edge; for n==0, on the 1st.
REQ-022 Start while busy SHALL be ignored with no effect on the operation in flight; start in the DONE cycle SHALL be ignored.
REQ-023 Address arithmetic SHALL wrap modulo 2^NW.
REQ-024 Without the saturation feature, accumulation SHALL wrap modulo 2^AW.
REQ-025 a_en and b_en SHALL be 0 outside FETCH.

Reset
REQ-026 Reset SHALL force IDLE and drive busy=0, done=0, a_en=b_en=0, a_addr=b_addr=0, result=0, accumulator=0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL run normally.

Configuration
REQ-028 Macro VEC_DOTPROD_SAT_EN defined: each accumulate SHALL clamp to the signed AW range [-2^(AW-1), 2^(AW-1)-1], and a sticky flag SHALL be set when clamping occurs.
REQ-029 With VEC_DOTPROD_SAT_EN defined, an extra output port sat (1 bit) SHALL report the sticky flag, valid alongside result and cleared on accept.
REQ-030 Macro undefined: port sat and the clamping logic are absent, and REQ-024 applies.

Structure
REQ-031 Shared package vec_dotprod_pkg SHALL hold the FSM state enum and the pipeline-depth constant (3).
REQ-032 Sub-module dotprod_adder_tree SHALL sum LANES signed 2*DW products into AW bits, combinationally, with log2(LANES) levels.

Verification
REQ-033 LANES=1, n=4, a=[1,2,3,4], b=[5,6,7,8] -> result=70; done on the 8th edge after the accept.
REQ-034 n=0 -> done on the 1st edge, result=0, a_en never high.
REQ-035 LANES=4, n=5, a=b=all 2, including the garbage lanes -> result=20 (tail lanes masked), B=2.
REQ-036 Signed operands, a=[-3,7], b=[4,-2] -> result=-26; start pulsed mid-run is ignored.
REQ-037 With VEC_DOTPROD_SAT_EN, DW=16, AW=32, 4 elements of a=b=-32768 -> result=2147483647, sat=1; without the macro -> result=0 (wrapped).
REQ-038 Reset asserted mid-FETCH -> outputs return to reset values with no done pulse; the next run of REQ-033 gives 70.
